// File: rtl/fourier_pkg.sv
// Shared encodings for the fourier_srg engine and its job controller.
package fourier_pkg;

  // Engine operation codes driven on eng_op.
  localparam logic [1:0] OP_IDLE    = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_COMPUTE = 2'b10;
  localparam logic [1:0] OP_READ    = 2'b11;

  // Job controller states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LOAD    = 3'd2,
    COMPUTE = 3'd3,
    READ    = 3'd4,
    RELEASE = 3'd5
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or after
// pointer (wrapping at NREQ) wins. The parent registers the result.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PTRW = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] pointer,
  output logic [NREQ-1:0] grant
);

  // Scan priority offsets 0..NREQ-1 from the pointer; take the first hit.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req[j] && (j == (int'(pointer) + i) % NREQ)) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fourier_job_ctrl.sv
// Job controller for the shared fourier_srg engine: arbitrates requesters
// round-robin, then clears the engine, loads N samples, runs the compute
// and streams N results back to the owner.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// s_valid/s_data come from the owner and are consumed when s_ready is high;
// m_valid/m_re/m_im/m_last/m_id are held stable while m_valid && !m_ready.
module fourier_job_ctrl
  import fourier_pkg::*;
#(
  parameter int N    = 100,
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             abort,
  output logic [NREQ-1:0]  grant,
  output logic             busy,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_re,
  output logic [31:0]      m_im,
  output logic             m_last,
  output logic [IDW-1:0]   m_id,
  output logic             eng_reset,
  output logic [31:0]      eng_addr,
  output logic [31:0]      eng_x,
  output logic [1:0]       eng_op,
  input  logic [31:0]      eng_y_re,
  input  logic [31:0]      eng_y_im,
  input  logic             eng_done
);

  localparam int CW = $clog2(N + 1);

  state_t          state, state_n;
  logic [NREQ-1:0] grant_q, grant_n, arb_gnt;
  logic [IDW-1:0]  m_id_q, m_id_n, rr_ptr, rr_ptr_n, arb_idx;
  logic [CW-1:0]   cnt, cnt_n;
  logic            rd_pend, rd_pend_n;
  logic            m_valid_q, m_valid_n, m_last_q, m_last_n;
  logic [31:0]     m_re_q, m_re_n, m_im_q, m_im_n;
  logic [1:0]      op;
  logic [31:0]     addr, x;
  logic            sr;
  logic            m_hs;

  rr_arbiter #(.NREQ(NREQ), .PTRW(IDW)) u_arb (
    .req     (req),
    .pointer (rr_ptr),
    .grant   (arb_gnt)
  );

  // Binary index of the arbiter's one-hot winner.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) arb_idx = IDW'(i);
    end
  end

  assign m_hs = m_valid_q && m_ready;

  // Next-state, datapath updates and engine command decode.
  always_comb begin
    state_n   = state;
    grant_n   = grant_q;
    m_id_n    = m_id_q;
    rr_ptr_n  = rr_ptr;
    cnt_n     = cnt;
    rd_pend_n = rd_pend;
    m_valid_n = m_valid_q;
    m_last_n  = m_last_q;
    m_re_n    = m_re_q;
    m_im_n    = m_im_q;
    op        = OP_IDLE;
    addr      = '0;
    x         = '0;
    sr        = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_n = arb_gnt;
          m_id_n  = arb_idx;
          cnt_n   = '0;
          state_n = CLEAR;
        end
      end
      CLEAR: begin
        state_n = abort ? RELEASE : LOAD;
      end
      LOAD: begin
        if (abort) begin
          state_n = RELEASE;
        end else begin
          sr = 1'b1;
          if (s_valid) begin
            op   = OP_WRITE;
            addr = 32'(cnt);
            x    = s_data;
            if (cnt == CW'(N - 1)) begin
              cnt_n   = '0;
              state_n = COMPUTE;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
        end
      end
      COMPUTE: begin
        if (abort) state_n = RELEASE;
        else if (eng_done) state_n = READ;
        else op = OP_COMPUTE;
      end
      READ: begin
        if (abort) begin
          state_n   = RELEASE;
          m_valid_n = 1'b0;
          m_last_n  = 1'b0;
          rd_pend_n = 1'b0;
        end else begin
          if (m_hs) begin
            m_valid_n = 1'b0;
            m_last_n  = 1'b0;
            if (m_last_q) state_n = RELEASE;
          end
          // A read issued last cycle always finds the output slot empty.
          if (rd_pend) begin
            m_re_n    = eng_y_re;
            m_im_n    = eng_y_im;
            m_valid_n = 1'b1;
            m_last_n  = (cnt == CW'(N - 1));
            cnt_n     = cnt + CW'(1);
            rd_pend_n = 1'b0;
          end else if ((cnt < CW'(N)) && (!m_valid_q || m_ready)) begin
            op        = OP_READ;
            addr      = 32'(cnt);
            rd_pend_n = 1'b1;
          end
        end
      end
      RELEASE: begin
        grant_n   = '0;
        rr_ptr_n  = (m_id_q == IDW'(NREQ - 1)) ? '0 : m_id_q + IDW'(1);
        m_valid_n = 1'b0;
        m_last_n  = 1'b0;
        rd_pend_n = 1'b0;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant_q   <= '0;
      m_id_q    <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      rd_pend   <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_re_q    <= '0;
      m_im_q    <= '0;
    end else begin
      state     <= state_n;
      grant_q   <= grant_n;
      m_id_q    <= m_id_n;
      rr_ptr    <= rr_ptr_n;
      cnt       <= cnt_n;
      rd_pend   <= rd_pend_n;
      m_valid_q <= m_valid_n;
      m_last_q  <= m_last_n;
      m_re_q    <= m_re_n;
      m_im_q    <= m_im_n;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state != IDLE);
  assign s_ready   = sr;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign m_re      = m_re_q;
  assign m_im      = m_im_q;
  assign m_id      = m_id_q;
  assign eng_reset = reset || (state == CLEAR);
  assign eng_op    = op;
  assign eng_addr  = addr;
  assign eng_x     = x;

endmodule

// File: doc/fourier_job_ctrl.md
Name: fourier_job_ctrl

Overview:
Job controller and arbiter for the shared fourier_srg DFT engine. Grants the engine to one of NREQ requesters at a time, round-robin. For each job it clears the engine, streams N samples in, runs the compute, and streams N complex results back to the owner. It sits between the requester fabric and a single fourier_srg instance, driving all of that instance's ports.

Parameters:
N, 100, DFT length; must equal the engine's n
NREQ, 2, number of requesters (2..8)
IDW, 3, width of m_id; must satisfy 2**IDW >= NREQ

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req  in  NREQ  per-requester job request (level)
abort  in  1  owner aborts current job
grant  out  NREQ  one-hot current owner
busy  out  1  job in progress
s_valid  in  1  input sample valid (from owner)
s_data  in  32  input sample
s_ready  out  1  sample accepted when s_valid&&s_ready
m_valid  out  1  result valid
m_ready  in  1  result consumed when m_valid&&m_ready
m_re  out  32  result real part
m_im  out  32  result imaginary part
m_last  out  1  marks result index N-1
m_id  out  IDW  index of the owning requester
eng_reset  out  1  engine reset
eng_addr  out  32  engine addr
eng_x  out  32  engine x
eng_op  out  2  engine operation
eng_y_re  in  32  engine y_re
eng_y_im  in  32  engine y_im
eng_done  in  1  engine done

Behaviour:
- Reset: the module uses reset, synchronous, active-high, on clock clk. state=IDLE; grant=0, busy=0, s_ready=0, m_valid=0, m_last=0, m_re=m_im=0, m_id=0, eng_op=00, eng_addr=0, eng_x=0, rr pointer=0. eng_reset=1 while reset is high (combinational OR with the CLEAR state).
- Engine ops: 00 idle, 01 write, 10 compute, 11 read. Read data is valid in the cycle after the read is issued.
- States and transitions:
  - IDLE: if any req bit is set, grant the first requester at or after the rr pointer (round-robin). Latch the grant and m_id, then go to CLEAR.
  - CLEAR: eng_reset=1 for exactly 1 cycle, then go to LOAD. This clears the engine's sticky done flag.
  - LOAD: s_ready=1. On each handshake: eng_op=01, eng_addr=cnt, eng_x=s_data, cnt++. After N accepted samples go to COMPUTE with cnt=0.
  - COMPUTE: hold eng_op=10 until eng_done=1, then set eng_op=00 and go to READ. No timeout.
  - READ: issue eng_op=11 with eng_addr=cnt only when no read is pending and the output slot is free or being consumed (!m_valid || m_ready).
    - The cycle after a read: capture eng_y_re/eng_y_im into m_re/m_im, set m_valid=1, m_last=(cnt==N-1), cnt++.
    - Maximum rate is 1 result per 2 cycles.
    - m_* are held stable while m_valid && !m_ready.
    - After the last result is handshaken go to RELEASE.
  - RELEASE: grant=0, rr pointer = owner+1 mod NREQ, then go to IDLE.
- busy=1 in every state except IDLE.
- grant stays asserted from CLEAR through READ. Dropping req mid-job has no effect.
- abort (sampled in CLEAR/LOAD/COMPUTE/READ): go to RELEASE next cycle; drop m_valid; eng_op=00; no m_last. The engine is cleared by the next job's CLEAR.
- In IDLE, s_ready=0 and m_valid=0. Samples offered while not granted are ignored.
- cnt is a $clog2(N+1)-bit counter; no wrap: exactly N writes and N reads per job.
- Reset mid-job: immediate return to IDLE with all outputs at reset values.

Decomposition:
- Shared package fourier_pkg: operation encodings (OP_IDLE, OP_WRITE, OP_COMPUTE, OP_READ) and the state enum (IDLE, CLEAR, LOAD, COMPUTE, READ, RELEASE). fourier_srg is updated to use the same encodings.
- Sub-module rr_arbiter #(NREQ): inputs req and pointer; output one-hot grant. Purely combinational, registered by the parent.

Test Plan:
- N=4 with a real engine: req[0]=1, samples 1,1,1,1 → results k=0 re=4*SCALE im=0, k=1..3 re=im=0 (±1 LSB); m_last only on k=3; m_id=0; one eng_reset pulse before the first write.
- N=4: samples 1,0,0,0 → all four results re=SCALE, im=0. With m_ready=0 for 5 cycles on k=1, m_re is held and no extra eng_op=11 is issued.
- req=2'b11 held for 3 jobs → grants in order 0,1,0, each preceded by a 1-cycle IDLE/RELEASE gap.
- abort asserted after 2 samples → busy drops within 2 cycles and no m_valid occurs. The next job from req[1] produces correct results (the engine was cleared).
- Reset asserted during COMPUTE → next cycle grant=0, busy=0, eng_reset=1, eng_op=00.
- s_valid toggling 1,0,1,0,... during LOAD → exactly 4 writes to eng_addr 0..3 with the matching eng_x values.
